// File: rtl/quiz_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   - BCD_W      : width of one BCD digit
//   - state_e    : converter FSM encoding (2 bits, code 3 is illegal)
//   - min_digits : smallest digit count that can hold 2^in_w - 1
package quiz_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int min_digits(input int in_w);
    longint unsigned maxv;
    longint unsigned pow10;
    int              d;
    maxv  = (64'd1 << in_w) - 64'd1;
    pow10 = 64'd10;
    d     = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= maxv) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq.
//   master : producer/consumer side (drives in_valid, bin_in, out_ready)
//   slave  : converter side (drives in_ready, out_valid, bcd_out, nz_digits)
interface bin2bcd_seq_if #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
);
  import quiz_pkg::*;

  localparam int NZ_W = $clog2(DIGITS + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [IN_W-1:0]           bin_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [BCD_W*DIGITS-1:0]   bcd_out;
  logic [NZ_W-1:0]           nz_digits;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, nz_digits
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, nz_digits
  );

endinterface

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
//   dig_i : current BCD digit (0..9)
//   dig_o : corrected digit (wraps in 4 bits, never overflows for 0..9)
module bcd_add3
  import quiz_pkg::*;
(
  input  logic [BCD_W-1:0] dig_i,
  output logic [BCD_W-1:0] dig_o
);

  assign dig_o = (dig_i >= BCD_W'(5)) ? (dig_i + BCD_W'(3)) : dig_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of bin2bcd_seq_if (operand in, packed BCD + digit count out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an operand, in_ready=1
// ST_SHIFT | one add-3/shift step per cycle, IN_W steps total
// ST_DONE  | result held, out_valid=1 until out_ready
module bin2bcd_seq
  import quiz_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BW    = BCD_W * DIGITS;
  localparam int NZ_W  = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(IN_W + 1);

  if (IN_W < 1 || IN_W > 32) begin : g_bad_width
    $error("bin2bcd_seq: IN_W=%0d outside 1..32", IN_W);
  end
  if (DIGITS < min_digits(IN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS=%0d too small for IN_W=%0d", DIGITS, IN_W);
  end

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IN_W-1:0]   bin_sr_q;
  logic [BW-1:0]     bcd_sr_q;
  logic [BW-1:0]     bcd_out_q;
  logic [NZ_W-1:0]   nz_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [BW-1:0]     corr;
  logic [BW-1:0]     bcd_sr_d;
  logic [IN_W-1:0]   bin_sr_d;
  logic [NZ_W-1:0]   nz_d;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .dig_i (bcd_sr_q[k*BCD_W +: BCD_W]),
      .dig_o (corr[k*BCD_W +: BCD_W])
    );
  end

  // Correct all digits, then shift the binary MSB into the BCD LSB.
  assign bcd_sr_d = {corr[BW-2:0], bin_sr_q[IN_W-1]};
  assign bin_sr_d = bin_sr_q << 1;

  // Highest non-zero digit wins; an all-zero result still shows one digit.
  always_comb begin
    nz_d = NZ_W'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_sr_d[k*BCD_W +: BCD_W] != '0) nz_d = NZ_W'(k + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      bcd_out_q   <= '0;
      nz_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            bin_sr_q   <= bus.bin_in;
            bcd_sr_q   <= '0;
            cnt_q      <= CNT_W'(IN_W);
            state_q    <= ST_SHIFT;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bin_sr_q <= bin_sr_d;
          bcd_sr_q <= bcd_sr_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= ST_DONE;
            bcd_out_q   <= bcd_sr_d;
            nz_q        <= nz_d;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.nz_digits = nz_q;

endmodule
